// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier
//   Multi-cycle shift-add multiplier. It retires one multiplier bit per clock
//   through a WIDTH+1-bit ripple adder built from full-adder cells. Signed
//   operands are reduced to magnitudes on capture, and the sign is applied
//   once the magnitude product is complete.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (aborts any operation)
//   start      request; honoured only in IDLE or DONE
//   a          multiplicand, captured on an accepted start
//   b          multiplier, captured on an accepted start
//   is_signed  1 = two's-complement operands, captured on an accepted start
//   busy       high while the product is being accumulated
//   done       one-cycle pulse when product is updated
//   product    2*WIDTH-bit result, held until the next completion
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_d;
  logic            accept;
  logic [WIDTH-1:0] mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_next;
  logic [WIDTH:0]   partial;
  logic [CW-1:0]    cnt;
  logic             neg;
  logic [PW-1:0]    product_q;

  // One bit-level full-adder cell: returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  // WIDTH-bit ripple chain of full-adder cells; the final carry is the MSB.
  function automatic logic [WIDTH:0] ripple_add(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    logic           c;
    logic [1:0]     fa;
    s = '0;
    c = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      fa   = full_add(x[i], y[i], c);
      s[i] = fa[0];
      c    = fa[1];
    end
    s[WIDTH] = c;
    return s;
  endfunction

  // Magnitude fits in WIDTH unsigned bits, including -2^(WIDTH-1) -> 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  // Applies the result sign; a zero magnitude stays zero regardless of sign.
  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] mag, input logic n);
    return (n && (mag != '0)) ? (~mag + PW'(1)) : mag;
  endfunction

  // Accumulator layout: upper half is the running partial sum, lower half
  // holds the not-yet-consumed multiplier bits, LSB first.
  always_comb begin
    partial  = ripple_add(acc[PW-1:WIDTH], acc[0] ? mcand : '0);
    acc_next = {partial, acc[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt == LAST) state_d = DONE;
      end
      DONE: begin
        accept  = start;
        state_d = start ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mcand     <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      product_q <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        mcand <= magnitude(a, is_signed);
        acc   <= {{WIDTH{1'b0}}, magnitude(b, is_signed)};
        cnt   <= '0;
        neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if (state == CALC) begin
        acc <= acc_next;
        cnt <= cnt + CW'(1);
        // The last step lands directly in the output register, so product
        // never exposes a partially accumulated value.
        if (cnt == LAST) product_q <= apply_sign(acc_next, neg);
      end
    end
  end

  assign busy    = (state == CALC);
  assign done    = (state == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
module tb_seq_shift_add_multiplier;

  logic clk;
  logic rst;

  // WIDTH=8 instance for directed scenarios
  logic        start8, sg8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;

  // Sweep instances
  logic        start2, sg2, busy2, done2;
  logic [1:0]  a2, b2;
  logic [3:0]  prod2;
  logic        start16, sg16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] prod16;
  logic        start32, sg32, busy32, done32;
  logic [31:0] a32, b32;
  logic [63:0] prod32;

  int          n_cmp;
  int          n_fail;
  logic [63:0] sb[$];
  logic [15:0] exp_prod8;

  seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .is_signed(sg8),
    .busy(busy8), .done(done8), .product(prod8));
  seq_shift_add_multiplier #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .is_signed(sg2),
    .busy(busy2), .done(done2), .product(prod2));
  seq_shift_add_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .is_signed(sg16),
    .busy(busy16), .done(done16), .product(prod16));
  seq_shift_add_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .is_signed(sg32),
    .busy(busy32), .done(done32), .product(prod32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  // Independent reference: signed/unsigned integer multiply, truncated to 2w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input bit s);
    logic [63:0] m;
    longint      vx, vy, p;
    m  = (w == 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    vx = longint'({32'b0, x & m[31:0]});
    vy = longint'({32'b0, y & m[31:0]});
    if (s && x[w-1]) vx = vx - (longint'(1) << w);
    if (s && y[w-1]) vy = vy - (longint'(1) << w);
    p = vx * vy;
    if (w == 32) return 64'(p);
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic drive_sw(input int idx, input logic [31:0] x, input logic [31:0] y,
                          input bit s, input bit st);
    case (idx)
      0: begin a2 = x[1:0];   b2 = y[1:0];   sg2 = s;  start2 = st;  end
      1: begin a16 = x[15:0]; b16 = y[15:0]; sg16 = s; start16 = st; end
      default: begin a32 = x; b32 = y; sg32 = s; start32 = st; end
    endcase
  endtask

  function automatic logic [63:0] prod_sw(input int idx);
    case (idx)
      0: return {60'b0, prod2};
      1: return {32'b0, prod16};
      default: return prod32;
    endcase
  endfunction

  function automatic logic busy_sw(input int idx);
    case (idx)
      0: return busy2;
      1: return busy16;
      default: return busy32;
    endcase
  endfunction

  function automatic logic done_sw(input int idx);
    case (idx)
      0: return done2;
      1: return done16;
      default: return done32;
    endcase
  endfunction

  task automatic test_power_on_reset();
    rst = 1'b1;
    start8 = 0; a8 = '0; b8 = '0; sg8 = 0;
    drive_sw(0, 0, 0, 0, 0);
    drive_sw(1, 0, 0, 0, 0);
    drive_sw(2, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0) begin
      n_fail++;
      $display("FAIL por_w8: busy=%b done=%b product=%h, required 0 0 0000", busy8, done8, prod8);
    end
    n_cmp++;
    if (busy32 !== 1'b0 || done32 !== 1'b0 || prod32 !== 64'h0 || prod16 !== 32'h0 || prod2 !== 4'h0) begin
      n_fail++;
      $display("FAIL por_sweep: busy32=%b done32=%b p32=%h p16=%h p2=%h, required all 0",
               busy32, done32, prod32, prod16, prod2);
    end
    rst = 1'b0;
    exp_prod8 = 16'h0;
  endtask

  // Unsigned maximum plus the signed boundary / zero cases, with full timing.
  task automatic test_directed();
    logic [7:0]  ta[4];
    logic [7:0]  tb_[4];
    bit          ts[4];
    logic [15:0] te[4];
    logic [63:0] exp;
    ta  = '{8'hFF, 8'h80, 8'hFD, 8'h00};
    tb_ = '{8'hFF, 8'h80, 8'h07, 8'hFB};
    ts  = '{1'b0, 1'b1, 1'b1, 1'b1};
    te  = '{16'hFE01, 16'h4000, 16'hFFEB, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a8 = ta[i]; b8 = tb_[i]; sg8 = ts[i]; start8 = 1'b1;
      sb.push_back({48'b0, te[i]});
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (c == 1) begin
          start8 = 1'b0;
          a8 = 8'($urandom); b8 = 8'($urandom); sg8 = ~sg8;
        end
        if (c <= 8) begin
          n_cmp++;
          if (busy8 !== 1'b1 || done8 !== 1'b0 || prod8 !== exp_prod8) begin
            n_fail++;
            $display("FAIL busy_window op%0d cyc%0d: busy=%b done=%b product=%h, required 1 0 %h",
                     i, c, busy8, done8, prod8, exp_prod8);
          end
        end else if (c == 9) begin
          n_cmp++;
          if (done8 !== 1'b1 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse op%0d: busy=%b done=%b, required busy=0 done=1", i, busy8, done8);
          end
          exp = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD;
          n_cmp++;
          if (prod8 !== exp[15:0]) begin
            n_fail++;
            $display("FAIL product op%0d: got %h, required %h", i, prod8, exp[15:0]);
          end
          exp_prod8 = exp[15:0];
        end else begin
          n_cmp++;
          if (done8 !== 1'b0 || busy8 !== 1'b0 || prod8 !== exp_prod8) begin
            n_fail++;
            $display("FAIL after_done op%0d: busy=%b done=%b product=%h, required 0 0 %h",
                     i, busy8, done8, prod8, exp_prod8);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0) begin
      n_fail++;
      $display("FAIL idle_reset: busy=%b done=%b product=%h, required 0 0 0000", busy8, done8, prod8);
    end
    rst = 1'b0;
    exp_prod8 = 16'h0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    @(negedge clk);
    a8 = 8'd12; b8 = 8'd13; sg8 = 1'b0; start8 = 1'b1;
    sb.push_back(64'd156);
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (c == 1) begin
        a8 = 8'd9; b8 = 8'd9;
        sb.push_back(64'd81);
      end
      if (c == 18) start8 = 1'b0;
      if (c == 19) begin
        n_cmp++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== exp_prod8) begin
          n_fail++;
          $display("FAIL b2b_idle: busy=%b done=%b product=%h, required 0 0 %h",
                   busy8, done8, prod8, exp_prod8);
        end
      end else if (c % 9 == 0) begin
        n_cmp++;
        if (done8 !== 1'b1 || busy8 !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_done cyc%0d: busy=%b done=%b, required busy=0 done=1", c, busy8, done8);
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD;
        n_cmp++;
        if (prod8 !== exp[15:0]) begin
          n_fail++;
          $display("FAIL b2b_product cyc%0d: got %h, required %h", c, prod8, exp[15:0]);
        end
        exp_prod8 = exp[15:0];
      end else begin
        n_cmp++;
        if (busy8 !== 1'b1 || done8 !== 1'b0 || prod8 !== exp_prod8) begin
          n_fail++;
          $display("FAIL b2b_busy cyc%0d: busy=%b done=%b product=%h, required 1 0 %h",
                   c, busy8, done8, prod8, exp_prod8);
        end
      end
    end
  endtask

  task automatic test_abort();
    int          dones;
    int          bad;
    logic [63:0] exp;
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd100; sg8 = 1'b0; start8 = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) start8 = 1'b0;
      n_cmp++;
      if (busy8 !== 1'b1 || done8 !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_busy cyc%0d: busy=%b done=%b, required 1 0", c, busy8, done8);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b done=%b product=%h, required 0 0 0000", busy8, done8, prod8);
    end
    rst = 1'b0;
    exp_prod8 = 16'h0;
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done8 !== 1'b0) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: %0d done pulses seen, required 0", dones);
    end
    a8 = 8'd2; b8 = 8'd3; start8 = 1'b1;
    sb.push_back(64'd6);
    bad = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) start8 = 1'b0;
      if (busy8 !== 1'b1 || done8 !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL post_abort_busy: %0d bad cycles, required 0", bad);
    end
    @(negedge clk);
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD;
    n_cmp++;
    if (done8 !== 1'b1 || prod8 !== exp[15:0]) begin
      n_fail++;
      $display("FAIL post_abort_product: done=%b product=%h, required done=1 product=%h",
               done8, prod8, exp[15:0]);
    end
  endtask

  task automatic test_sweep(input int idx, input int w);
    logic [31:0] ra, rb;
    bit          rs;
    logic [63:0] exp;
    logic [63:0] got;
    int          bad;
    for (int op = 0; op < 1000; op++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      if (op == 0) begin ra = '1; rb = '1; end
      if (op == 1 || op == 2) begin ra = 32'd1 << (w - 1); rb = 32'd1 << (w - 1); end
      if (op == 3 || op == 4) begin ra = 32'd0; rb = '1; end
      if (op >= 1 && op <= 4) rs = (op % 2 == 1);
      @(negedge clk);
      drive_sw(idx, ra, rb, rs, 1'b1);
      sb.push_back(ref_mul(w, ra, rb, rs));
      bad = 0;
      for (int c = 1; c <= w; c++) begin
        @(negedge clk);
        if (c == 1) drive_sw(idx, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        if (busy_sw(idx) !== 1'b1 || done_sw(idx) !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL sweep_busy w%0d op%0d: %0d bad cycles, required 0", w, op, bad);
      end
      @(negedge clk);
      n_cmp++;
      if (done_sw(idx) !== 1'b1 || busy_sw(idx) !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep_done w%0d op%0d: busy=%b done=%b, required 0 1",
                 w, op, busy_sw(idx), done_sw(idx));
      end
      exp = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD;
      got = prod_sw(idx);
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL sweep_product w%0d op%0d a=%h b=%h s=%0d: got %h, required %h",
                 w, op, ra, rb, rs, got, exp);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_power_on_reset();
    test_directed();
    test_reset();
    test_back_to_back();
    test_abort();
    test_sweep(0, 2);
    test_sweep(1, 16);
    test_sweep(2, 32);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
